ram_rr_arbiter: RTL

//  Two-port round-robin arbiter that shares the single-port 8x8 RAM between requesters A and B.

---
 rtl/ram_rr_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter
// Shares one single-port RAM between two requesters, A and B. Each requester
// issues a single read or write with a req/ack handshake. The arbiter grants
// one command at a time in round-robin order. It drives the RAM for one cycle
// and then returns the result with a one-cycle ack pulse.
//
// Ports
//   clk, rst                          clock; asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata         command from requester A
//   a_ack/a_rdata                     completion pulse and read result for A
//   b_*                               the same set of signals for requester B
//   ram_write_en/address/write_data   drive the RAM; this block is their only driver
//   ram_read_data                     registered RAM read data (1-cycle latency)
//   busy                              high while a command is in ISSUE or RESP
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for an eligible request; grant and latch the command
// ISSUE  | RAM port driven with the latched command for one cycle
// RESP   | read data valid from RAM; ack and rdata to the granted side

module ram_rr_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;     // 0: A wins a tie, 1: B wins a tie
    logic              id_q, id_d;         // 0: A granted, 1: B granted
    logic              we_q, we_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              ram_write_en_q, ram_write_en_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_write_data_q, ram_write_data_d;
    logic              busy_q, busy_d;

    logic elig_a, elig_b, grant_b;

    // A requester whose ack is high right now is finishing its command. Its
    // held req must not be granted again in the same cycle.
    assign elig_a  = a_req & ~a_ack_q;
    assign elig_b  = b_req & ~b_ack_q;
    assign grant_b = elig_b & (~elig_a | prio_q);

    always_comb begin
        state_d          = state_q;
        prio_d           = prio_q;
        id_d             = id_q;
        we_d             = we_q;
        a_ack_d          = 1'b0;
        b_ack_d          = 1'b0;
        a_rdata_d        = a_rdata_q;
        b_rdata_d        = b_rdata_q;
        ram_write_en_d   = ram_write_en_q;
        ram_address_d    = ram_address_q;
        ram_write_data_d = ram_write_data_q;

        case (state_q)
            S_IDLE: begin
                if (elig_a || elig_b) begin
                    id_d             = grant_b;
                    prio_d           = ~grant_b;
                    we_d             = grant_b ? b_we : a_we;
                    ram_write_en_d   = grant_b ? b_we : a_we;
                    ram_address_d    = grant_b ? b_addr : a_addr;
                    ram_write_data_d = grant_b ? b_wdata : a_wdata;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ram_write_en_d = 1'b0;
                state_d        = S_RESP;
            end
            S_RESP: begin
                if (id_q) begin
                    b_ack_d = 1'b1;
                    if (!we_q) b_rdata_d = ram_read_data;
                end else begin
                    a_ack_d = 1'b1;
                    if (!we_q) a_rdata_d = ram_read_data;
                end
                state_d = S_IDLE;
            end
            default: begin
                ram_write_en_d = 1'b0;
                state_d        = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            prio_q           <= 1'b0;
            id_q             <= 1'b0;
            we_q             <= 1'b0;
            a_ack_q          <= 1'b0;
            b_ack_q          <= 1'b0;
            a_rdata_q        <= '0;
            b_rdata_q        <= '0;
            ram_write_en_q   <= 1'b0;
            ram_address_q    <= '0;
            ram_write_data_q <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            prio_q           <= prio_d;
            id_q             <= id_d;
            we_q             <= we_d;
            a_ack_q          <= a_ack_d;
            b_ack_q          <= b_ack_d;
            a_rdata_q        <= a_rdata_d;
            b_rdata_q        <= b_rdata_d;
            ram_write_en_q   <= ram_write_en_d;
            ram_address_q    <= ram_address_d;
            ram_write_data_q <= ram_write_data_d;
            busy_q           <= busy_d;
        end
    end

    assign a_ack          = a_ack_q;
    assign b_ack          = b_ack_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;
    assign ram_write_en   = ram_write_en_q;
    assign ram_address    = ram_address_q;
    assign ram_write_data = ram_write_data_q;
    assign busy           = busy_q;

endmodule
